// File: rtl/sram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving a dual-port SRAM with an
// asynchronous read port; the SRAM holds the data, this block holds pointers and status.
module sram_fifo_ctrl #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow,
    output logic [AW-1:0] ad_wr,
    output logic [DW-1:0] wr_d,
    output logic          w_en,
    output logic [AW-1:0] ad_rd,
    input  logic [DW-1:0] rd_d
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [AW:0]   count_next;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    // A full FIFO can still take a push when the head is consumed on the same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | pop);

    assign w_en     = do_push & ~rst;
    assign ad_wr    = wr_ptr;
    assign wr_d     = push_data;
    assign ad_rd    = rd_ptr;
    assign pop_data = rd_d;

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count - 1'b1;
        end
    end

    // full/empty derive from the next count so they stay registered yet aligned with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_next;
            full  <= (count_next == DEPTH_C);
            empty <= (count_next == '0);
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural 16x8 async-read SRAM attached.
module tb_sram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic [7:0] push_data;
    logic       pop;
    logic [7:0] pop_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic [3:0] ad_wr;
    logic [7:0] wr_d;
    logic       w_en;
    logic [3:0] ad_rd;
    logic [7:0] rd_d;

    logic [7:0] mem [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_fifo_ctrl #(.DW(8), .DEPTH(16), .AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .ad_wr     (ad_wr),
        .wr_d      (wr_d),
        .w_en      (w_en),
        .ad_rd     (ad_rd),
        .rd_d      (rd_d)
    );

    // SRAM: synchronous write, asynchronous read
    always @(posedge clk) begin
        if (w_en) mem[ad_wr] <= wr_d;
    end
    assign rd_d = mem[ad_rd];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called just after a rising edge; inputs settle before combinational checks.
    task automatic applyStimulus(input logic p, input logic [7:0] d, input logic q);
        push      = p;
        push_data = d;
        pop       = q;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        push = 1'b0;
        push_data = 8'h00;
        pop = 1'b0;
        tick();
        applyStimulus(1'b1, 8'hEE, 1'b0);
        checkOutput("w_en_in_reset", w_en, 0);
        tick();
        checkOutput("count_in_reset", count, 0);
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_w_en", w_en, 0);
        checkOutput("rst_ad_wr", ad_wr, 0);
        checkOutput("rst_ad_rd", ad_rd, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_underflow", underflow, 0);

        $display("[TB] fill with 0xA0..0xAF");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0);
            checkOutput("fill_w_en", w_en, 1);
            checkOutput("fill_ad_wr", ad_wr, i);
            tick();
            checkOutput("fill_count", count, i + 1);
            if (i == 0) checkOutput("fwft_head", pop_data, 8'hA0);
        end
        checkOutput("fill_full", full, 1);
        checkOutput("fill_empty", empty, 0);

        $display("[TB] overflow");
        applyStimulus(1'b1, 8'hFF, 1'b0);
        checkOutput("ovf_w_en", w_en, 0);
        tick();
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_count", count, 16);
        checkOutput("ovf_head", pop_data, 8'hA0);
        checkOutput("ovf_full", full, 1);

        $display("[TB] push+pop while full");
        applyStimulus(1'b1, 8'h5A, 1'b1);
        checkOutput("pp_full_head", pop_data, 8'hA0);
        checkOutput("pp_full_w_en", w_en, 1);
        checkOutput("pp_full_ad_wr", ad_wr, 0);
        tick();
        checkOutput("pp_full_count", count, 16);
        checkOutput("pp_full_full", full, 1);

        $display("[TB] drain");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("drain_data", pop_data, (i < 15) ? 8'(8'hA1 + i) : 8'h5A);
            tick();
            checkOutput("drain_count", count, 15 - i);
        end
        checkOutput("drain_empty", empty, 1);
        checkOutput("drain_full", full, 0);

        $display("[TB] underflow");
        applyStimulus(1'b0, 8'h00, 1'b1);
        tick();
        checkOutput("udf_flag", underflow, 1);
        checkOutput("udf_count", count, 0);
        checkOutput("udf_empty", empty, 1);
        checkOutput("ovf_sticky", overflow, 1);

        $display("[TB] push+pop while empty");
        applyStimulus(1'b1, 8'h3C, 1'b1);
        checkOutput("pp_empty_w_en", w_en, 1);
        checkOutput("pp_empty_ad_wr", ad_wr, 1);
        tick();
        checkOutput("pp_empty_count", count, 1);
        checkOutput("pp_empty_empty", empty, 0);
        checkOutput("pp_empty_data", pop_data, 8'h3C);
        checkOutput("pp_empty_udf", underflow, 1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        tick();
        checkOutput("pp_empty_drained", empty, 1);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 8'(8'h70 + i), 1'b0);
            tick();
        end
        checkOutput("mid_count7", count, 7);
        applyStimulus(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 8'h99, 1'b0);
        checkOutput("mid_count0", count, 0);
        checkOutput("mid_empty", empty, 1);
        checkOutput("mid_ovf_clr", overflow, 0);
        checkOutput("mid_udf_clr", underflow, 0);
        checkOutput("mid_ad_wr", ad_wr, 0);
        checkOutput("mid_w_en", w_en, 1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("mid_data", pop_data, 8'h99);
        checkOutput("mid_ad_rd", ad_rd, 0);
        tick();
        checkOutput("mid_drained", empty, 1);

        $display("[TB] wrap-around");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
            tick();
        end
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            tick();
        end
        checkOutput("wrap_pre_empty", empty, 1);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 8'(8'h11 * (k + 1)), 1'b0);
            checkOutput("wrap_ad_wr", ad_wr, (10 + k) % 16);
            tick();
        end
        checkOutput("wrap_count", count, 12);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("wrap_ad_rd", ad_rd, (10 + k) % 16);
            checkOutput("wrap_data", pop_data, 8'(8'h11 * (k + 1)));
            tick();
        end
        checkOutput("wrap_empty", empty, 1);
        checkOutput("wrap_count0", count, 0);
        checkOutput("wrap_no_udf", underflow, 0);

        applyStimulus(1'b0, 8'h00, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Synchronous FIFO controller sitting directly upstream of the dual-port asynchronous-read SRAM (16x8).
- Accepts a push/pop stream from the producer and consumer.
- Drives the SRAM write port (ad_wr, wr_d, w_en) and read address (ad_rd).
- Returns the SRAM's combinational rd_d as first-word-fall-through pop data.
- Keeps pointers, occupancy count, full/empty and sticky error flags.

Parameters:
- DW, 8, data width; matches the SRAM word.
- DEPTH, 16, number of SRAM words used; any value from 2 to 2^AW.
- AW, 4, SRAM address width.

Ports:
- clk  in  1  single clock; SRAM shares it.
- rst  in  1  synchronous, active-high reset.
- push  in  1  producer write request.
- push_data  in  DW  data to store.
- pop  in  1  consumer read request; acknowledges the current pop_data.
- pop_data  out  DW  head-of-FIFO word; valid whenever empty=0.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.
- ad_wr  out  AW  SRAM write address = wr_ptr.
- wr_d  out  DW  SRAM write data = push_data (combinational).
- w_en  out  1  SRAM write enable.
- ad_rd  out  AW  SRAM read address = rd_ptr.
- rd_d  in  DW  SRAM asynchronous read data.

Behaviour:
- Reset (clk edge with rst=1):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, overflow=0, underflow=0.
  - While rst=1, w_en is forced to 0 and no pointer moves.
  - SRAM contents are not cleared.
  - Reset mid-stream discards all queued data; the next push after reset lands at address 0.
- Accept rules, evaluated at each posedge with rst=0:
  - do_pop = pop & ~empty.
  - do_push = push & (~full | pop).
  - A push while full is accepted only when a pop happens in the same cycle.
  - A pop while empty is always rejected, even with a simultaneous push; that push is still accepted.
- w_en = do_push (combinational). The SRAM captures wr_d at ad_wr on the same edge.
- Pointer updates:
  - On do_push, wr_ptr advances: wraps from DEPTH-1 to 0; otherwise +1.
  - On do_pop, rd_ptr advances with the same wrap rule.
- Count update on each edge:
  - count += 1 on push-only.
  - count -= 1 on pop-only.
  - Unchanged on both or neither.
- full, empty and count are registered and consistent with the pointers in the same cycle.
- Data path:
  - ad_rd = rd_ptr; pop_data = rd_d, so there is zero-cycle read latency.
  - A word pushed at edge N is visible on pop_data after edge N (within the same cycle) if the FIFO was empty.
  - pop_data is don't-care while empty=1.
- Full with simultaneous push and pop: wr_ptr==rd_ptr. The pre-edge rd_d is the old head word, consumed at this edge. The new word is written to the same location at this edge. Count stays at DEPTH.
- Error flags:
  - overflow sets on push & ~do_push.
  - underflow sets on pop & empty.
  - Both hold until rst.
- No combinational path from pop or push to full, empty or count.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> empty=1, full=0, count=0, w_en=0, ad_wr=0, ad_rd=0, flags=0.
- Fill and drain:
  - Push 0xA0..0xAF on 16 consecutive cycles -> full=1 and count=16 after the 16th edge.
  - Pop 16 cycles -> pop_data sequence 0xA0..0xAF, then empty=1 and count=0.
- Wrap-around:
  - Push 10 words, pop 10, then push 0x11,0x22,0x33,... 12 words -> ad_wr goes 10..15,0..5.
  - Pops return the 12 words in order; no data loss.
- Overflow and underflow:
  - Push a 17th word 0xFF while full and pop=0 -> rejected, w_en=0, overflow=1, count stays 16, head still 0xA0.
  - From empty, pop=1 -> underflow=1, count stays 0.
- Simultaneous push and pop:
  - When full: push 0x5A with pop -> pop_data=old head before the edge, count=16; 0x5A appears last in the drain.
  - When empty: push 0x3C with pop -> count=1, underflow=1, pop_data=0x3C next cycle.
- Reset mid-operation: with count=7, assert rst for 1 cycle -> count=0, empty=1; the next push 0x99 is written at ad_wr=0 and popped as 0x99.
